cke_sched: RTL and testbench
============================

# cke_sched

Clock-enable scheduler that drives the `cke_tx`, `cke_rx_p` and `cke_rx_n` inputs of the emulator clock generator. Each system cycle it advances emulated time to the earliest pending event among three channels (TX edge, RX positive edge, RX negative edge). It then asserts the enable of every channel due at that instant, so the gated clocks tick in correct emulated-time order. Per-channel intervals come from upstream jitter/period logic and are sampled when a channel fires.

## Interface

Parameters:
- `TIME_W`, 40, width of the emulated-time accumulator (time units).
- `DT_W`, 24, width of per-channel interval inputs and internal timers.

Ports:
- `clk_sys`  in  1  system clock; the ungated clock from the clock generator.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; scheduler advances only while high.
- `stall`  in  1  level; freezes all state for the current cycle, with no enables.
- `dt_tx`  in  DT_W  interval to the next TX edge, sampled when TX fires or loads.
- `dt_rx_p`  in  DT_W  interval to the next RX positive edge, same sampling rule.
- `dt_rx_n`  in  DT_W  interval to the next RX negative edge, same sampling rule.
- `cke_tx`  out  1  TX clock enable to the clock generator.
- `cke_rx_p`  out  1  RX positive-edge clock enable.
- `cke_rx_n`  out  1  RX negative-edge clock enable.
- `emu_time`  out  TIME_W  emulated time of the most recent firing.
- `time_ovf`  out  1  sticky; set when `emu_time` wraps.
- `busy`  out  1  high in LOAD and RUN.

## Operation

- States: IDLE, LOAD, RUN.
- IDLE:
  - All `cke_*` are 0; timers hold.
  - `run`=1 → LOAD.
- LOAD (exactly one cycle):
  - Timers load `dt_*`, clamped (a value of 0 is treated as 1).
  - `cke_*`=0; `emu_time` unchanged.
  - Next state is RUN.
- RUN with `stall`=0 and `run`=1:
  - m = min(timer_tx, timer_rx_p, timer_rx_n).
  - For each channel with timer == m: cke <= 1 and timer <= clamp(dt).
  - For every other channel: cke <= 0 and timer <= timer − m.
  - `emu_time` <= `emu_time` + m, modulo 2^TIME_W.
  - A carry out sets `time_ovf`.
- RUN with `stall`=1: all `cke_*` <= 0; timers, `emu_time` and state hold.
- RUN with `run`=0: → IDLE, `cke_*` <= 0; timers and `emu_time` are retained. A later `run`=1 goes through LOAD again, which reloads the timers.
- Simultaneous firing: every channel whose timer equals m fires in the same cycle; there is no priority among channels.
- In every unstalled RUN cycle at least one `cke_*` is 1.
- Arithmetic:
  - Timers are unsigned DT_W.
  - m is at least 1 by construction, thanks to the clamp.
  - timer − m never underflows.
  - `emu_time` accumulates m zero-extended to TIME_W.
- Reset:
  - `rst`=1 at any time, including mid-RUN or during `stall`, forces the following on the next edge: state IDLE, all `cke_*`=0, timers 0, `emu_time` 0, `time_ovf` 0, `busy` 0.
  - `rst` overrides `run` and `stall`.

## Timing

- All outputs are registered on `clk_sys` rising edge.
- Reset values: `cke_*`=0, `emu_time`=0, `time_ovf`=0, `busy`=0.
- Each `cke_*` assertion lasts exactly one `clk_sys` cycle per firing. A channel may fire on consecutive cycles if its interval is the minimum each time.
- `dt_*` is sampled on the same edge at which that channel's `cke` goes high, and on the LOAD edge. Upstream must present the next interval combinationally valid before that edge.
- Latency:
  - `run` rising → first enable is 2 cycles later (IDLE→LOAD→RUN edge).
  - `stall` affects the enables on the next edge.
- `emu_time` updates on the same edge as the corresponding `cke_*`.

## Structure

- Package `cke_pkg`:
  - `ch_e` enum: CH_TX, CH_RX_P, CH_RX_N.
  - `NUM_CH`=3.
  - `state_e` enum: IDLE, LOAD, RUN.
  - Clamp function `dt_clamp`.
- Sub-module `cke_min`, combinational: takes three DT_W timers and outputs m plus a 3-bit one-hot-or-multi "due" mask.
- The top level holds the FSM, timers, accumulator and output registers.

## Test plan

- Equal intervals: reset, `run`=1, `dt_tx`=`dt_rx_p`=`dt_rx_n`=10 → from cycle 2 all three `cke` high every cycle; `emu_time` = 10, 20, 30.
- Staggered intervals: `dt_tx`=4, `dt_rx_p`=6, `dt_rx_n`=6 offset by one LOAD at 3 (`dt_rx_n`=3 in LOAD, then 6) → fire order rx_n@3, tx@4, rx_p@6, rx_n@9, tx@8 before it. `emu_time` is monotonic; each firing matches a hand-computed merge.
- Zero clamp: `dt_tx`=0, others 5 → tx fires every cycle; `emu_time` increments by 1.
- Stall: assert `stall` for 3 cycles mid-RUN → `cke_*`=0 during the stall; `emu_time` and the fire sequence resume unchanged afterwards.
- Wrap: TIME_W=8, all dt=100 → third firing `emu_time`=44 with `time_ovf`=1, staying set.
- Reset mid-RUN: `rst` pulse while `cke_tx`=1 → next cycle all outputs 0, state IDLE; `run` held high → LOAD then normal firing from `emu_time` 0.

Source files
------------

// File: rtl/cke_pkg.sv
// Shared types and helpers for the clock-enable scheduler.
// Channel indices, FSM states and the interval clamp.
package cke_pkg;

  typedef enum logic [1:0] {
    CH_TX   = 2'd0,
    CH_RX_P = 2'd1,
    CH_RX_N = 2'd2
  } ch_e;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Zero intervals would stall emulated time, so they count as one unit.
  function automatic logic [63:0] dt_clamp(input logic [63:0] dt);
    return (dt == 64'd0) ? 64'd1 : dt;
  endfunction

endpackage

// File: rtl/cke_min.sv
// Combinational earliest-event finder for the three channel timers.
// Outputs the minimum and the mask of every channel at that minimum.
module cke_min
  import cke_pkg::*;
#(
  parameter int DT_W = 24
) (
  input  logic [DT_W-1:0]   i_t_tx,
  input  logic [DT_W-1:0]   i_t_rx_p,
  input  logic [DT_W-1:0]   i_t_rx_n,
  output logic [DT_W-1:0]   o_m,
  output logic [NUM_CH-1:0] o_due
);

  logic [DT_W-1:0] w_m01;

  // Two-level compare; ties are all flagged due, with no priority.
  always_comb begin
    w_m01 = (i_t_tx < i_t_rx_p) ? i_t_tx : i_t_rx_p;
    o_m   = (w_m01 < i_t_rx_n) ? w_m01 : i_t_rx_n;
    o_due = '0;
    o_due[int'(CH_TX)]   = (i_t_tx == o_m);
    o_due[int'(CH_RX_P)] = (i_t_rx_p == o_m);
    o_due[int'(CH_RX_N)] = (i_t_rx_n == o_m);
  end

endmodule

// File: rtl/cke_sched.sv
// Clock-enable scheduler: advances emulated time to the earliest
// pending channel event and enables every channel due at that instant.
module cke_sched
  import cke_pkg::*;
#(
  parameter int TIME_W = 40,
  parameter int DT_W   = 24
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              run,
  input  logic              stall,
  input  logic [DT_W-1:0]   dt_tx,
  input  logic [DT_W-1:0]   dt_rx_p,
  input  logic [DT_W-1:0]   dt_rx_n,
  output logic              cke_tx,
  output logic              cke_rx_p,
  output logic              cke_rx_n,
  output logic [TIME_W-1:0] emu_time,
  output logic              time_ovf,
  output logic              busy
);

  // Sum is wide enough for either operand so no carry is lost,
  // even when an interval is wider than the time accumulator.
  localparam int SW = ((TIME_W > DT_W) ? TIME_W : DT_W) + 1;

  state_e            r_state;
  logic [DT_W-1:0]   r_tmr [NUM_CH];
  logic [NUM_CH-1:0] r_cke;
  logic [TIME_W-1:0] r_emu;
  logic              r_ovf;
  logic              r_busy;

  logic [DT_W-1:0]   w_dt   [NUM_CH];
  logic [DT_W-1:0]   w_m;
  logic [NUM_CH-1:0] w_due;
  logic [SW-1:0]     w_sum;
  logic              w_wrap;

  // Clamped next intervals, indexed by channel.
  always_comb begin
    w_dt[int'(CH_TX)]   = DT_W'(dt_clamp(64'(dt_tx)));
    w_dt[int'(CH_RX_P)] = DT_W'(dt_clamp(64'(dt_rx_p)));
    w_dt[int'(CH_RX_N)] = DT_W'(dt_clamp(64'(dt_rx_n)));
  end

  cke_min #(
    .DT_W (DT_W)
  ) u_min (
    .i_t_tx   (r_tmr[int'(CH_TX)]),
    .i_t_rx_p (r_tmr[int'(CH_RX_P)]),
    .i_t_rx_n (r_tmr[int'(CH_RX_N)]),
    .o_m      (w_m),
    .o_due    (w_due)
  );

  // Next emulated time and its wrap indication.
  always_comb begin
    w_sum  = SW'(r_emu) + SW'(w_m);
    w_wrap = |(w_sum >> TIME_W);
  end

  // FSM, timers, time accumulator and registered enables.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state <= IDLE;
      r_cke   <= '0;
      r_emu   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_tmr[c] <= '0;
    end else if (stall) begin
      r_cke <= '0;
    end else begin
      r_cke <= '0;
      unique case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          for (int c = 0; c < NUM_CH; c++) r_tmr[c] <= w_dt[c];
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
        RUN: begin
          if (!run) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (w_due[c]) begin
                r_cke[c] <= 1'b1;
                r_tmr[c] <= w_dt[c];
              end else begin
                r_tmr[c] <= r_tmr[c] - w_m;
              end
            end
            r_emu <= w_sum[TIME_W-1:0];
            if (w_wrap) r_ovf <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cke_tx   = r_cke[int'(CH_TX)];
  assign cke_rx_p = r_cke[int'(CH_RX_P)];
  assign cke_rx_n = r_cke[int'(CH_RX_N)];
  assign emu_time = r_emu;
  assign time_ovf = r_ovf;
  assign busy     = r_busy;

endmodule

// File: tb/tb_cke_sched.sv
// Bench for cke_sched: absolute-time event model, directed and random.
// Two instances run in lockstep: default width and an 8-bit time width.
module tb_cke_sched;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic [23:0] dt_tx = '0;
  logic [23:0] dt_rx_p = '0;
  logic [23:0] dt_rx_n = '0;

  logic        cke_tx, cke_rx_p, cke_rx_n, time_ovf, busy;
  logic [39:0] emu_time;
  logic        c8_tx, c8_rx_p, c8_rx_n, ovf8, busy8;
  logic [7:0]  t8;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk_sys = ~clk_sys;

  cke_sched u_dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .run      (run),
    .stall    (stall),
    .dt_tx    (dt_tx),
    .dt_rx_p  (dt_rx_p),
    .dt_rx_n  (dt_rx_n),
    .cke_tx   (cke_tx),
    .cke_rx_p (cke_rx_p),
    .cke_rx_n (cke_rx_n),
    .emu_time (emu_time),
    .time_ovf (time_ovf),
    .busy     (busy)
  );

  cke_sched #(.TIME_W(8)) u_d8 (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .run      (run),
    .stall    (stall),
    .dt_tx    (dt_tx),
    .dt_rx_p  (dt_rx_p),
    .dt_rx_n  (dt_rx_n),
    .cke_tx   (c8_tx),
    .cke_rx_p (c8_rx_p),
    .cke_rx_n (c8_rx_n),
    .emu_time (t8),
    .time_ovf (ovf8),
    .busy     (busy8)
  );

  // Model: absolute time of now and of each channel's next event.
  longint   m_now = 0;
  longint   m_next [3];
  int       m_st = 0;
  logic [2:0] m_cke = '0;

  function automatic longint dtv(input int c);
    longint v;
    v = (c == 0) ? longint'(dt_tx) :
        (c == 1) ? longint'(dt_rx_p) : longint'(dt_rx_n);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [57:0] want();
    logic [39:0] t40;
    logic [7:0]  tt8;
    t40 = m_now[39:0];
    tt8 = m_now[7:0];
    return {m_cke, m_st != 0, t40, m_now >= (64'd1 << 40),
            tt8, m_now >= 256, m_st != 0, m_cke};
  endfunction

  function automatic logic [57:0] got();
    return {cke_rx_n, cke_rx_p, cke_tx, busy, emu_time, time_ovf,
            t8, ovf8, busy8, c8_rx_n, c8_rx_p, c8_tx};
  endfunction

  // Advance the model with the current inputs, then one clock.
  task automatic step();
    longint t;
    m_cke = '0;
    if (rst) begin
      m_now = 0;
      m_st  = 0;
      for (int c = 0; c < 3; c++) m_next[c] = 0;
    end else if (!stall) begin
      case (m_st)
        0: if (run) m_st = 1;
        1: begin
          for (int c = 0; c < 3; c++) m_next[c] = m_now + dtv(c);
          m_st = 2;
        end
        default: begin
          if (!run) m_st = 0;
          else begin
            t = m_next[0];
            for (int c = 1; c < 3; c++) if (m_next[c] < t) t = m_next[c];
            for (int c = 0; c < 3; c++)
              if (m_next[c] == t) begin
                m_cke[c] = 1'b1;
                m_next[c] = t + dtv(c);
              end
            m_now = t;
          end
        end
      endcase
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_dt(input int a, input int b, input int c);
    dt_tx   = 24'(a);
    dt_rx_p = 24'(b);
    dt_rx_n = 24'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if (got() !== 58'd0) begin
        n_err++;
        $display("FAIL reset_state got=%h want=0", got());
      end
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (got() !== want()) begin
      n_err++;
      $display("FAIL reset_idle got=%h want=%h", got(), want());
    end
  endtask

  task automatic test_equal();
    rst = 1'b1; step(); rst = 1'b0;
    set_dt(10, 10, 10);
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (got() !== want()) begin
        n_err++;
        $display("FAIL equal_model i=%0d got=%h want=%h", i, got(), want());
      end
    end
    n_chk++;
    if ({cke_rx_n, cke_rx_p, cke_tx} !== 3'b111 || emu_time !== 40'd40) begin
      n_err++;
      $display("FAIL equal_hand cke=%b time=%0d want 111/40",
               {cke_rx_n, cke_rx_p, cke_tx}, emu_time);
    end
  endtask

  task automatic test_stagger();
    int   et [6];
    logic [2:0] ec [6];
    et = '{3, 4, 6, 8, 9, 12};
    ec = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b100, 3'b011};
    rst = 1'b1; step(); rst = 1'b0;
    set_dt(4, 6, 3);
    run = 1'b1;
    step();
    step();
    dt_rx_n = 24'd6;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (got() !== want()) begin
        n_err++;
        $display("FAIL stagger_model i=%0d got=%h want=%h", i, got(), want());
      end
      n_chk++;
      if ({cke_rx_n, cke_rx_p, cke_tx} !== ec[i] || emu_time !== 40'(et[i])) begin
        n_err++;
        $display("FAIL stagger_hand i=%0d cke=%b t=%0d want %b/%0d", i,
                 {cke_rx_n, cke_rx_p, cke_tx}, emu_time, ec[i], et[i]);
      end
    end
  endtask

  task automatic test_zero_clamp();
    rst = 1'b1; step(); rst = 1'b0;
    set_dt(0, 5, 5);
    run = 1'b1;
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      n_chk++;
      if (cke_tx !== 1'b1 || emu_time !== 40'(i + 1) || got() !== want()) begin
        n_err++;
        $display("FAIL zero_clamp i=%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_stall();
    logic [39:0] hold;
    set_dt(3, 5, 7);
    step();
    step();
    hold = emu_time;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({cke_rx_n, cke_rx_p, cke_tx} !== 3'b000 || emu_time !== hold ||
          busy !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold i=%0d cke=%b t=%0d want 000/%0d", i,
                 {cke_rx_n, cke_rx_p, cke_tx}, emu_time, hold);
      end
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (got() !== want()) begin
        n_err++;
        $display("FAIL stall_resume i=%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_wrap();
    int   et [5];
    logic eo [5];
    et = '{100, 200, 44, 144, 244};
    eo = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1; step(); rst = 1'b0;
    set_dt(100, 100, 100);
    run = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (t8 !== 8'(et[i]) || ovf8 !== eo[i] || time_ovf !== 1'b0 ||
          got() !== want()) begin
        n_err++;
        $display("FAIL wrap i=%0d t8=%0d ovf8=%b want %0d/%b", i,
                 t8, ovf8, et[i], eo[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1; step(); rst = 1'b0;
    set_dt(2, 3, 5);
    run = 1'b1;
    n = 0;
    while (cke_tx !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n_chk++;
    if (cke_tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_wait cke_tx=%b want 1 within 20", cke_tx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++;
    if (got() !== 58'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear got=%h want=0", got());
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_chk++;
      if (got() !== want()) begin
        n_err++;
        $display("FAIL reset_mid_rerun i=%0d got=%h want=%h", i, got(), want());
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      run   = ($urandom_range(0, 9) != 0);
      stall = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 19) == 0)
        set_dt($urandom_range(0, 1 << 20), $urandom_range(0, 15),
               $urandom_range(0, 15));
      else
        set_dt($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15));
      step();
      n_chk++;
      if (got() !== want()) begin
        n_err++;
        $display("FAIL random i=%0d got=%h want=%h", i, got(), want());
      end
    end
    rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_stagger();
    test_zero_clamp();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
